// File: rtl/rom_arb_pkg.sv
// Shared types for the instruction-ROM read-port arbiter.
// Arbiter FSM states, port-ownership encoding and a small round-robin helper.
package rom_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  // The requester that did not own the port last; used to alternate under contention.
  function automatic arb_owner_t other_owner(input arb_owner_t owner);
    return (owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Combinational 2-way grant between the fetch port and the data-read port.
// Build option: ROM_ARB_FIXED_PRIO_EN -> fetch always wins contention (no history input);
// otherwise the requester that did not own the port last wins contention.
import rom_arb_pkg::*;

module rom_arb_grant (
  input  logic eff_if,
  input  logic eff_d,
`ifndef ROM_ARB_FIXED_PRIO_EN
  input  logic last_owner,
`endif
  output logic winner
);

  // Pick the winner among the effective requests; fetch is the don't-care default.
  always_comb begin
    winner = OWN_FETCH;
`ifdef ROM_ARB_FIXED_PRIO_EN
    if (eff_if) begin
      winner = OWN_FETCH;
    end else if (eff_d) begin
      winner = OWN_DATA;
    end else begin
      winner = OWN_FETCH;
    end
`else
    if (eff_if && eff_d) begin
      winner = other_owner(arb_owner_t'(last_owner));
    end else if (eff_d) begin
      winner = OWN_DATA;
    end else begin
      winner = OWN_FETCH;
    end
`endif
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single instruction-ROM read port between instruction fetch (IF)
// and data-side table/constant reads (D). Grants one access at a time: the
// address is registered in the grant cycle, the ROM word is captured one cycle
// later and returned with a one-cycle valid pulse to the owner.
// Build option: ROM_ARB_FIXED_PRIO_EN -> fetch has fixed priority over data reads.
import rom_arb_pkg::*;

module rom_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd
);

  arb_state_t            state_r;
  arb_state_t            state_s;
  arb_owner_t            owner_r;
  arb_owner_t            owner_s;
  logic                  flush_pend_r;
  logic                  flush_pend_s;
  logic [ADDR_WIDTH-1:0] rom_addr_s;
  logic                  if_valid_s;
  logic                  d_valid_s;
  logic [DATA_WIDTH-1:0] if_rdata_s;
  logic [DATA_WIDTH-1:0] d_rdata_s;
  logic                  eff_if_s;
  logic                  eff_d_s;
  logic                  winner_s;
`ifndef ROM_ARB_FIXED_PRIO_EN
  arb_owner_t            last_owner_r;
  arb_owner_t            last_owner_s;
`endif

  // A requester is masked in its own valid cycle so a held request is not served twice.
  assign eff_if_s = if_req & ~if_valid;
  assign eff_d_s  = d_req & ~d_valid;

  rom_arb_grant u_grant (
    .eff_if     (eff_if_s),
    .eff_d      (eff_d_s),
`ifndef ROM_ARB_FIXED_PRIO_EN
    .last_owner (last_owner_r),
`endif
    .winner     (winner_s)
  );

  // Next-state, address sequencing and response capture; everything holds by default.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    flush_pend_s = flush_pend_r;
    rom_addr_s   = rom_addr;
    if_valid_s   = 1'b0;
    d_valid_s    = 1'b0;
    if_rdata_s   = if_rdata;
    d_rdata_s    = d_rdata;
`ifndef ROM_ARB_FIXED_PRIO_EN
    last_owner_s = last_owner_r;
`endif
    case (state_r)
      ARB_IDLE: begin
        if (eff_if_s || eff_d_s) begin
          state_s    = ARB_BUSY;
          owner_s    = arb_owner_t'(winner_s);
          rom_addr_s = (arb_owner_t'(winner_s) == OWN_FETCH) ? if_addr : d_addr;
`ifndef ROM_ARB_FIXED_PRIO_EN
          last_owner_s = arb_owner_t'(winner_s);
`endif
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // BUSY lasts one cycle, so a flush seen now is folded in directly and the
        // pending flag is cleared on the way out.
        state_s      = ARB_IDLE;
        flush_pend_s = 1'b0;
        if (owner_r == OWN_FETCH) begin
          if_rdata_s = rom_rd;
          if_valid_s = ~(flush_pend_r | if_flush);
        end else begin
          d_rdata_s = rom_rd;
          d_valid_s = 1'b1;
        end
      end
      default: begin
        state_s      = ARB_IDLE;
        flush_pend_s = 1'b0;
      end
    endcase
  end

  // State, address and response registers; async reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      owner_r      <= OWN_FETCH;
      flush_pend_r <= 1'b0;
      rom_addr     <= {ADDR_WIDTH{1'b0}};
      if_valid     <= 1'b0;
      d_valid      <= 1'b0;
      if_rdata     <= {DATA_WIDTH{1'b0}};
      d_rdata      <= {DATA_WIDTH{1'b0}};
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_owner_r <= OWN_DATA;
`endif
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      flush_pend_r <= flush_pend_s;
      rom_addr     <= rom_addr_s;
      if_valid     <= if_valid_s;
      d_valid      <= d_valid_s;
      if_rdata     <= if_rdata_s;
      d_rdata      <= d_rdata_s;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_owner_r <= last_owner_s;
`endif
    end
  end

endmodule
